split_assign_driver: RTL and testbench

- Sequential stimulus engine on the driving side of a split constraint checker.
- Walks candidate variable assignments and drives them as one packed bus; the bench/top slices the bus into var_0..var_N.
- Samples the checker's single-bit result x for each candidate and streams each satisfying assignment out over a valid/ready interface.
- Used to enumerate or confirm solutions of split constraint blocks, including trivially-true ones where x is tied high.

---
 rtl/split_pkg.sv | 15 +
 rtl/split_sol_skid.sv | 35 +++
 rtl/split_assign_driver.sv | 146 ++++++++++++++
 tb/tb_split_assign_driver.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/split_pkg.sv
// Shared types and default widths for the split constraint stimulus driver.
package split_pkg;

  localparam int ASSIGN_W_DEF = 64;
  localparam int TRY_W_DEF    = 16;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    EMIT,
    FIN
  } state_e;

endpackage

// File: rtl/split_sol_skid.sv
// One-entry solution holding register with valid/ready output handshake.
module split_sol_skid #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         flush_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         hs_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign hs_o    = valid_q && ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (flush_i || hs_o) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/split_assign_driver.sv
// Walks candidate assignments into a split checker and streams out the
// candidates for which the checker result is high.
module split_assign_driver
  import split_pkg::*;
#(
  parameter int ASSIGN_W = ASSIGN_W_DEF,
  parameter int TRY_W    = TRY_W_DEF,
  parameter int SETTLE   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ASSIGN_W-1:0] seed,
  input  logic [TRY_W-1:0]    max_tries,
  input  logic                first_only,
  input  logic                abort,
  output logic [ASSIGN_W-1:0] assign_o,
  input  logic                chk_x,
  output logic                sol_valid,
  input  logic                sol_ready,
  output logic [ASSIGN_W-1:0] sol_data,
  output logic                busy,
  output logic                done,
  output logic [TRY_W-1:0]    found_cnt
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SLAST = SW'(SETTLE - 1);

  state_e              state_q;
  logic [ASSIGN_W-1:0] cand_q;
  logic [ASSIGN_W-1:0] assign_q;
  logic [TRY_W-1:0]    tries_q;
  logic [TRY_W-1:0]    max_q;
  logic [TRY_W-1:0]    found_q;
  logic [SW-1:0]       settle_q;
  logic                first_q;

  logic                sol_hs;
  logic                sol_load;
  logic                sol_flush;
  logic                adv;
  logic                last;
  logic [TRY_W-1:0]    tries_nx;
  logic [ASSIGN_W-1:0] cand_nx;

  assign tries_nx = tries_q + TRY_W'(1);
  assign cand_nx  = cand_q + ASSIGN_W'(1);
  assign last     = (tries_nx == max_q);

  assign sol_load  = (state_q == SAMPLE) && chk_x && !abort;
  assign sol_flush = (state_q == EMIT) && abort;

  // Abort wins over advancing; a same-cycle handshake is still counted.
  assign adv = ((state_q == SAMPLE) && !abort && !chk_x) ||
               ((state_q == EMIT) && sol_hs && !abort && !first_q);

  assign assign_o  = assign_q;
  assign found_cnt = found_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);

  split_sol_skid #(
    .W(ASSIGN_W)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load_i (sol_load),
    .data_i (cand_q),
    .flush_i(sol_flush),
    .ready_i(sol_ready),
    .valid_o(sol_valid),
    .data_o (sol_data),
    .hs_o   (sol_hs)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cand_q   <= '0;
      assign_q <= '0;
      tries_q  <= '0;
      max_q    <= '0;
      found_q  <= '0;
      settle_q <= '0;
      first_q  <= 1'b0;
    end else begin
      if (sol_hs && (found_q != '1)) begin
        found_q <= found_q + TRY_W'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            cand_q   <= seed;
            tries_q  <= '0;
            found_q  <= '0;
            max_q    <= max_tries;
            first_q  <= first_only;
            settle_q <= '0;
            if (max_tries == '0) begin
              state_q <= FIN;
            end else begin
              assign_q <= seed;
              state_q  <= DRIVE;
            end
          end
        end
        DRIVE: begin
          if (abort) begin
            state_q <= FIN;
          end else if (settle_q == SLAST) begin
            state_q <= SAMPLE;
          end else begin
            settle_q <= settle_q + SW'(1);
          end
        end
        SAMPLE: begin
          if (abort) begin
            state_q <= FIN;
          end else if (chk_x) begin
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (abort || (sol_hs && first_q)) begin
            state_q <= FIN;
          end
        end
        FIN: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (adv) begin
        tries_q <= tries_nx;
        if (last) begin
          state_q <= FIN;
        end else begin
          cand_q   <= cand_nx;
          assign_q <= cand_nx;
          settle_q <= '0;
          state_q  <= DRIVE;
        end
      end
    end
  end

endmodule

// File: tb/tb_split_assign_driver.sv
// Directed and randomized bench for split_assign_driver with an
// enumeration-level reference model of the expected solution stream.
module tb_split_assign_driver;

  localparam int SETTLE = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] seed;
  logic [15:0] max_tries;
  logic        first_only;
  logic        abort;
  logic [63:0] assign_o;
  logic        chk_x;
  logic        sol_valid;
  logic        sol_ready;
  logic [63:0] sol_data;
  logic        busy;
  logic        done;
  logic [15:0] found_cnt;

  int          checks = 0;
  int          errors = 0;
  int          pmode = 0;
  logic [63:0] key = '0;
  logic [63:0] mask = '0;
  int          fv_cyc;
  int          fh_cyc;

  split_assign_driver #(
    .ASSIGN_W(64),
    .TRY_W   (16),
    .SETTLE  (SETTLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seed      (seed),
    .max_tries (max_tries),
    .first_only(first_only),
    .abort     (abort),
    .assign_o  (assign_o),
    .chk_x     (chk_x),
    .sol_valid (sol_valid),
    .sol_ready (sol_ready),
    .sol_data  (sol_data),
    .busy      (busy),
    .done      (done),
    .found_cnt (found_cnt)
  );

  always #5 clk = ~clk;

  // Emulated constraint checker: 0 tied true, 1 equality, 2 masked match.
  function automatic bit pred(input logic [63:0] a, input int m,
                              input logic [63:0] k, input logic [63:0] msk);
    case (m)
      0: return 1'b1;
      1: return a == k;
      default: return ((a ^ k) & msk) == 64'd0;
    endcase
  endfunction

  always_comb chk_x = pred(assign_o, pmode, key, mask);

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // rm: 0 ready held high, 1 random ready, 2 ready low 4 cycles then high
  task automatic run_check(input string tag, input logic [63:0] s,
                           input logic [15:0] mt, input bit fo,
                           input int pm, input int rm,
                           input logic [63:0] k, input logic [63:0] msk);
    logic [63:0] expq[$];
    logic [63:0] gotq[$];
    logic [63:0] c;
    logic [63:0] hd;
    logic [63:0] ha;
    int          ncand;
    int          bcnt;
    int          cyc;
    int          vcnt;
    int          n;
    bit          dn;
    bit          hold;
    pmode = pm;
    key   = k;
    mask  = msk;
    ncand = int'(mt);
    for (int i = 0; i < int'(mt); i++) begin
      c = s + 64'(i);
      if (pred(c, pm, k, msk)) begin
        expq.push_back(c);
        if (fo) begin
          ncand = i + 1;
          break;
        end
      end
    end
    @(negedge clk);
    seed       = s;
    max_tries  = mt;
    first_only = fo;
    sol_ready  = (rm == 0);
    start      = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    dn     = 1'b0;
    hold   = 1'b0;
    bcnt   = 0;
    cyc    = 0;
    vcnt   = 0;
    hd     = '0;
    ha     = '0;
    fv_cyc = -1;
    fh_cyc = -1;
    while (!dn && cyc < 4000) begin
      if (rm == 1) begin
        sol_ready = 1'($urandom % 2);
      end else if (rm == 2) begin
        if (sol_valid) vcnt++;
        sol_ready = (vcnt >= 5);
      end
      if (hold) begin
        chk({tag, "-hold-valid"}, 64'(sol_valid), 64'd1);
        chk({tag, "-hold-data"}, sol_data, hd);
        chk({tag, "-hold-assign"}, assign_o, ha);
      end
      if (sol_valid && fv_cyc < 0) fv_cyc = cyc;
      if (sol_valid && sol_ready) begin
        gotq.push_back(sol_data);
        if (fh_cyc < 0) fh_cyc = cyc;
      end
      hold = sol_valid && !sol_ready;
      hd   = sol_data;
      ha   = assign_o;
      if (busy) bcnt++;
      if (done) begin
        dn = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk({tag, "-done-seen"}, 64'(dn), 64'd1);
    chk({tag, "-nsol"}, 64'(gotq.size()), 64'(expq.size()));
    n = (gotq.size() < expq.size()) ? gotq.size() : expq.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "-sol"}, gotq[i], expq[i]);
    end
    chk({tag, "-found"}, 64'(found_cnt), 64'(expq.size()));
    if (rm == 0) begin
      chk({tag, "-cycles"}, 64'(bcnt),
          64'(ncand * (SETTLE + 1) + expq.size() + 1));
    end
    @(negedge clk);
    chk({tag, "-done-pulse"}, 64'(done), 64'd0);
    chk({tag, "-idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int          w;
    logic [63:0] s;
    logic [15:0] mt;
    bit          fo;
    int          pm;
    int          rm;
    rst        = 1'b1;
    start      = 1'b0;
    seed       = '0;
    max_tries  = '0;
    first_only = 1'b0;
    abort      = 1'b0;
    sol_ready  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst-assign", assign_o, 64'd0);
    chk("rst-valid", 64'(sol_valid), 64'd0);
    chk("rst-data", sol_data, 64'd0);
    chk("rst-busy", 64'(busy), 64'd0);
    chk("rst-done", 64'(done), 64'd0);
    chk("rst-found", 64'(found_cnt), 64'd0);
    rst = 1'b0;

    run_check("t1", 64'd5, 16'd3, 1'b0, 0, 0, '0, '0);
    run_check("t2", 64'd0, 16'd16, 1'b0, 1, 0, 64'd9, '0);
    run_check("t3", 64'h40, 16'd1, 1'b0, 0, 2, '0, '0);
    chk("t3-accept", 64'(fh_cyc - fv_cyc), 64'd4);
    run_check("t4-wrap", '1, 16'd2, 1'b0, 0, 0, '0, '0);
    run_check("t4-first", '1, 16'd2, 1'b1, 0, 0, '0, '0);

    // abort while a solution is stalled
    pmode = 0;
    @(negedge clk);
    seed = 64'h10; max_tries = 16'd5; first_only = 1'b0;
    sol_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!sol_valid && w < 50) begin @(negedge clk); w++; end
    chk("t5-reach", 64'(w < 50), 64'd1);
    chk("t5-found0", 64'(found_cnt), 64'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5-drop", 64'(sol_valid), 64'd0);
    chk("t5-done", 64'(done), 64'd1);
    chk("t5-found", 64'(found_cnt), 64'd0);
    @(negedge clk);
    chk("t5-done-off", 64'(done), 64'd0);
    chk("t5-idle", 64'(busy), 64'd0);

    // abort together with a handshake
    @(negedge clk);
    seed = 64'h20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!sol_valid && w < 50) begin @(negedge clk); w++; end
    chk("t5b-reach", 64'(w < 50), 64'd1);
    abort = 1'b1; sol_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5b-found", 64'(found_cnt), 64'd1);
    chk("t5b-done", 64'(done), 64'd1);
    chk("t5b-drop", 64'(sol_valid), 64'd0);
    @(negedge clk);

    // reset in the middle of DRIVE
    @(negedge clk);
    seed = 64'h77; max_tries = 16'd4; sol_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!(found_cnt == 16'd1 && !sol_valid && busy) && w < 50) begin
      @(negedge clk); w++;
    end
    chk("t6-reach", 64'(w < 50), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6-busy", 64'(busy), 64'd0);
    chk("t6-assign", assign_o, 64'd0);
    chk("t6-found", 64'(found_cnt), 64'd0);
    chk("t6-done", 64'(done), 64'd0);
    chk("t6-valid", 64'(sol_valid), 64'd0);
    @(negedge clk);
    chk("t6-nodone", 64'(done), 64'd0);

    run_check("t5-zero", 64'h1234, 16'd0, 1'b0, 0, 0, '0, '0);
    chk("t5-zero-assign", assign_o, 64'd0);
    run_check("t6-after", 64'h300, 16'd6, 1'b0, 2, 0, 64'h1, 64'h1);

    for (int r = 0; r < 10; r++) begin
      s = {$urandom, $urandom};
      if (r % 3 == 0) s = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom % 16);
      mt = 16'(1 + $urandom % 20);
      fo = 1'($urandom % 2);
      pm = int'($urandom % 3);
      rm = int'($urandom % 2);
      run_check("rnd", s, mt, fo, pm, rm, s + 64'($urandom % 24),
                64'($urandom % 8));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
